idli_dout_buf_m: RTL



---
 rtl/idli_dout_buf_m.sv | 73 +++++++
 1 files changed

// File: rtl/idli_dout_buf_m.sv
// Nibble output buffer between the core data output and the chip pins.
// A small FIFO with independent core-side and pin-side valid/accept handshakes.
module idli_dout_buf_m #(
    parameter  int DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             i_dout_gck,
    input  logic             i_dout_rst,
    input  logic [3:0]       i_dout_din,
    input  logic             i_dout_din_vld,
    output logic             o_dout_din_acp,
    output logic [3:0]       o_dout_pin,
    output logic             o_dout_pin_vld,
    input  logic             i_dout_pin_acp,
    input  logic             i_dout_flush,
    output logic [LVL_W-1:0] o_dout_level,
    output logic             o_dout_empty,
    output logic             o_dout_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [3:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    always_comb begin
        empty          = (level == '0);
        full           = (level == LVL_W'(DEPTH));
        o_dout_din_acp = !full && !i_dout_flush;
        o_dout_pin_vld = !empty;
        o_dout_pin     = empty ? 4'h0 : mem[rd_ptr];
        o_dout_level   = level;
        o_dout_empty   = empty;
        o_dout_full    = full;
        push           = i_dout_din_vld && o_dout_din_acp;
        pop            = o_dout_pin_vld && i_dout_pin_acp;
    end

    // Storage is deliberately not reset; pointers and level define validity.
    always_ff @(posedge i_dout_gck) begin
        if (push) begin
            mem[wr_ptr] <= i_dout_din;
        end
    end

    // Level is kept separately from the pointers to tell full from empty.
    always_ff @(posedge i_dout_gck) begin
        if (i_dout_rst || i_dout_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule
